// File: rtl/bcd_scan_controller.sv
// rtl/bcd_scan_controller.sv - time-multiplexed BCD digit scanner with guarded slots and frame-synchronous reload
module bcd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [3:0]              bcd_out,
    output logic                    dec_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    dp_out,
    output logic                    frame_tick,
    output logic                    bcd_err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CYC_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CYC_SHOW  = CW'(BLANK_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;
    // With no guard cycles the slot opens directly in SHOW.
    localparam logic [0:0] ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [CW-1:0]           cyc_q, cyc_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [0:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] active_q, pending_q;
    logic [NUM_DIGITS-1:0]   dp_active_q, pend_dp_q;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q;

    logic [3:0]              bcd_out_q;
    logic                    dec_en_q;
    logic [NUM_DIGITS-1:0]   digit_sel_q;
    logic                    dp_out_q;
    logic                    tick_q;
    logic                    err_q;

    logic                    cyc_wrap, slot_wrap;
    logic                    show, bad_code, lz_suppress;
    logic                    accept, commit;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    zero_run;

    always_comb begin
        cyc_wrap  = (cyc_q == CYC_LAST);
        slot_wrap = cyc_wrap && (slot_q == SLOT_LAST);
        cyc_d     = cyc_wrap ? '0 : cyc_q + CW'(1);
        slot_d    = slot_q;
        if (cyc_wrap) begin
            slot_d = slot_wrap ? '0 : slot_q + SW'(1);
        end
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cyc_d == CYC_SHOW) state_d = ST_SHOW;
            ST_SHOW:  if (cyc_wrap) state_d = ST_SLOT_START;
            default:  state_d = ST_BLANK;
        endcase
    end

    // zero_above[i] is set when every digit from the top down to i is zero.
    always_comb begin
        zero_run   = 1'b1;
        zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (active_q[4*i +: 4] == 4'd0);
            zero_above[i] = zero_run;
        end
    end

    always_comb begin
        cur_code    = active_q[{slot_q, 2'b00} +: 4];
        cur_dp      = dp_active_q[slot_q];
        show        = (state_q == ST_SHOW);
        bad_code    = (cur_code > 4'd9);
        lz_suppress = lz_blank && (slot_q != '0) && zero_above[slot_q];
        accept      = load_valid && ready_q;
        commit      = tick_q && pend_full_q;
        pend_full_d = pend_full_q;
        if (accept) begin
            pend_full_d = 1'b1;
        end else if (commit) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= '0;
            slot_q      <= '0;
            state_q     <= ST_SLOT_START;
            active_q    <= '0;
            dp_active_q <= '0;
            pending_q   <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            cyc_q       <= cyc_d;
            slot_q      <= slot_d;
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            ready_q     <= !pend_full_d;
            if (accept) begin
                pending_q <= bcd_in;
                pend_dp_q <= dp_in;
            end
            // tick_q marks the final visible cycle of the frame, so the swap lands in the next slot-0 guard.
            if (commit) begin
                active_q    <= pending_q;
                dp_active_q <= pend_dp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out_q   <= '0;
            dec_en_q    <= 1'b0;
            digit_sel_q <= '0;
            dp_out_q    <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bcd_out_q   <= show ? cur_code : 4'd0;
            dec_en_q    <= show && !bad_code && !lz_suppress;
            digit_sel_q <= show ? (NUM_DIGITS'(1) << slot_q) : '0;
            dp_out_q    <= show && cur_dp;
            tick_q      <= slot_wrap;
            err_q       <= err_q || (show && bad_code);
        end
    end

    assign load_ready = ready_q;
    assign bcd_out    = bcd_out_q;
    assign dec_en     = dec_en_q;
    assign digit_sel  = digit_sel_q;
    assign dp_out     = dp_out_q;
    assign frame_tick = tick_q;
    assign bcd_err    = err_q;

endmodule

// File: tb/tb_bcd_scan_controller.sv
// tb/tb_bcd_scan_controller.sv - scoreboard bench for bcd_scan_controller
module tb_bcd_scan_controller;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * RD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [4*N-1:0] bcd_in = '0;
    logic [N-1:0]  dp_in = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    bcd_out;
    logic          dec_en;
    logic [N-1:0]  digit_sel;
    logic          dp_out;
    logic          frame_tick;
    logic          bcd_err;

    bcd_scan_controller #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .lz_blank  (lz_blank),
        .bcd_out   (bcd_out),
        .dec_en    (dec_en),
        .digit_sel (digit_sel),
        .dp_out    (dp_out),
        .frame_tick(frame_tick),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       en;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] en);
        for (int s = 0; s < N; s++) begin
            exp_t e;
            e.sel = 4'(1 << s);
            e.bcd = bcd[4*s +: 4];
            e.en  = en[s];
            e.dp  = dp[s];
            exp_q.push_back(e);
        end
    endtask

    task automatic load(input logic [15:0] bcd, input logic [3:0] dp);
        load_valid = 1'b1;
        bcd_in     = bcd;
        dp_in      = dp;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (frame_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_tick: got no frame_tick expected one within %0d cycles", FRAME + 8);
    endtask

    // Monitor: sample after each edge, pop an expectation at every slot's first SHOW cycle.
    int       n = 0;
    int       blank_run = 0;
    int       show_run = 0;
    logic [N-1:0] prev_sel = '0;
    exp_t     got;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            n = 0;
            blank_run = 0;
            show_run = 0;
            prev_sel = '0;
        end else begin
            n++;
            if (frame_tick || (n % FRAME == 0))
                check("frame_tick_period", frame_tick, (n % FRAME == 0));
            if (digit_sel != '0 && prev_sel == '0) begin
                check("blank_guard_len", blank_run, BC);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slot: got digit_sel %0h expected no slot", digit_sel);
                end else begin
                    got = exp_q.pop_front();
                    check("digit_sel", digit_sel, got.sel);
                    check("bcd_out", bcd_out, got.bcd);
                    check("dec_en", dec_en, got.en);
                    check("dp_out", dp_out, got.dp);
                end
                blank_run = 0;
                show_run = 0;
            end
            if (digit_sel == '0 && prev_sel != '0) begin
                check("show_len", show_run, RD - BC);
                show_run = 0;
                blank_run = 0;
            end
            if (digit_sel == '0) blank_run++;
            else show_run++;
            prev_sel = digit_sel;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_digit_sel", digit_sel, 0);
        check("rst_dec_en", dec_en, 0);
        check("rst_bcd_out", bcd_out, 0);
        check("rst_dp_out", dp_out, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_bcd_err", bcd_err, 0);
        check("rst_load_ready", load_ready, 1);

        push_frame(16'h0000, 4'b0000, 4'b1111);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        load(16'h4321, 4'b0100);
        check("ready_low_after_accept", load_ready, 0);
        wait_tick();
        check("ready_low_on_tick", load_ready, 0);
        push_frame(16'h4321, 4'b0100, 4'b1111);
        @(negedge clk);
        check("ready_back_after_commit", load_ready, 1);

        load(16'h1111, 4'b0000);
        load_valid = 1'b1;
        bcd_in     = 16'h2222;
        repeat (5) @(negedge clk);
        check("ready_low_backpressure", load_ready, 0);
        load_valid = 1'b0;
        wait_tick();
        push_frame(16'h1111, 4'b0000, 4'b1111);
        @(negedge clk);
        load(16'h3333, 4'b1000);
        wait_tick();
        push_frame(16'h3333, 4'b1000, 4'b1111);

        @(negedge clk);
        lz_blank = 1'b1;
        load(16'h0050, 4'b0000);
        wait_tick();
        push_frame(16'h0050, 4'b0000, 4'b0011);
        @(negedge clk);
        load(16'h0000, 4'b0000);
        wait_tick();
        push_frame(16'h0000, 4'b0000, 4'b0001);

        @(negedge clk);
        load(16'h00A3, 4'b0000);
        wait_tick();
        lz_blank = 1'b0;
        check("bcd_err_clear_before_bad", bcd_err, 0);
        push_frame(16'h00A3, 4'b0000, 4'b1101);
        @(negedge clk);
        load(16'h0009, 4'b0000);
        wait_tick();
        check("bcd_err_set", bcd_err, 1);
        push_frame(16'h0009, 4'b0000, 4'b1111);
        wait_tick();
        check("bcd_err_sticky", bcd_err, 1);
        push_frame(16'h0009, 4'b0000, 4'b1111);

        @(negedge clk);
        load(16'h7777, 4'b1111);
        repeat (18) @(negedge clk);
        check("ready_low_pending_full", load_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_digit_sel", digit_sel, 0);
        check("midrst_load_ready", load_ready, 1);
        check("midrst_bcd_err", bcd_err, 0);
        check("midrst_dec_en", dec_en, 0);
        exp_q.delete();
        push_frame(16'h0000, 4'b0000, 4'b1111);
        rst = 1'b0;
        wait_tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_load_ready", load_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_controller.md
Name: bcd_scan_controller

Overview:
Time-multiplexing scheduler that shares one BCD-to-7-segment decoder among NUM_DIGITS common-cathode digits. It holds a frame of BCD digits and presents one digit at a time to the shared decoder. Each digit gets a fixed refresh slot, preceded by a blanking guard that suppresses ghosting. New frames are accepted through a valid/ready handshake and take effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 1000, clock cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 2, cycles at the start of each slot during which all digits are off

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  new frame offered on bcd_in/dp_in
load_ready  output  1  pending buffer empty; frame accepted when load_valid && load_ready
bcd_in  input  4*NUM_DIGITS  digit i on bits [4i+3:4i]; digit 0 is least significant
dp_in  input  NUM_DIGITS  decimal point per digit
lz_blank  input  1  leading-zero blanking enable (sampled live)
bcd_out  output  4  BCD code to the shared decoder's a,b,c,d inputs
dec_en  output  1  decoder output enable; 0 blanks segments
digit_sel  output  NUM_DIGITS  one-hot digit enable, active-high
dp_out  output  1  decimal point for the selected digit
frame_tick  output  1  one-cycle pulse on the last cycle of each frame
bcd_err  output  1  sticky flag: a digit code > 9 has been displayed

Behaviour:
- Reset values (all outputs registered): bcd_out=0, dec_en=0, digit_sel=0, dp_out=0, frame_tick=0, bcd_err=0, load_ready=1. Internal: active frame=0, pending empty, slot=0, cyc=0, state=BLANK.
- Slot counter cyc runs 0..REFRESH_DIV-1 and then wraps to 0. On wrap, slot advances 0..NUM_DIGITS-1 and then wraps to 0.
- State machine has two states, BLANK and SHOW.
  - BLANK covers cyc 0..BLANK_CYCLES-1. Outputs: digit_sel=0, dec_en=0, dp_out=0.
  - SHOW covers cyc BLANK_CYCLES..REFRESH_DIV-1. Outputs: digit_sel=1<<slot, bcd_out=active[slot], dp_out=dp_active[slot], dec_en=1 unless the digit is suppressed.
  - Transition BLANK->SHOW when cyc reaches BLANK_CYCLES. Transition SHOW->BLANK on slot wrap.
- Output timing: outputs reflect state one register stage late. The first BLANK_CYCLES cycles after reset release show all digits off.
- Suppression: dec_en=0 (digit_sel still asserted) in two cases.
  - The code is > 9. In this case bcd_err is also set (sticky until rst).
  - lz_blank=1, slot>0, and every digit from NUM_DIGITS-1 down to slot is 0. Digit 0 is never suppressed by blanking.
- Handshake:
  - On load_valid && load_ready, the pending buffer captures bcd_in/dp_in and load_ready drops to 0 on the next cycle.
  - load_valid while load_ready=0 is ignored; no data is lost from pending.
- Commit:
  - On the last cycle of slot NUM_DIGITS-1 (frame_tick=1), if pending is full, active<=pending and pending empties; load_ready=1 on the next cycle.
  - A load accepted on the frame_tick cycle itself (pending was empty) is held until the following frame end.
- Latency: an accepted frame is displayed starting at the next slot-0 SHOW phase, at most one full frame later.
- A reset asserted mid-slot or mid-frame returns everything to reset values on the next edge. The pending frame is discarded.
- frame_tick fires every NUM_DIGITS*REFRESH_DIV cycles. The first pulse occurs NUM_DIGITS*REFRESH_DIV cycles after reset release.

Test Plan:
1. Reset/scan, with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2:
   - Stimulus: release rst.
   - Required: digit_sel=0000 for 2 cycles, then 0001 for 6 cycles, 0000 for 2 cycles, 0010 for 6 cycles, and so on. frame_tick is a single pulse every 32 cycles. All bcd_out=0, dec_en=1 (lz_blank=0).
2. Load/commit:
   - Stimulus: load bcd_in=0x4321 mid-frame.
   - Required: load_ready=0 until the frame_tick cycle, then 1 on the next cycle. Next frame shows bcd_out 1,2,3,4 on slots 0..3. The current frame is unchanged.
3. Back-pressure:
   - Stimulus: load 0x1111, then offer 0x2222 while load_ready=0, then 0x3333 after ready returns.
   - Required: display sequence is 0x1111 then 0x3333. 0x2222 never appears.
4. Leading-zero blanking:
   - Stimulus: frame 0x0050 with lz_blank=1.
   - Required: dec_en=0 on slots 3 and 2. dec_en=1 on slot 1 (5) and slot 0 (0).
   - Stimulus: frame 0x0000.
   - Required: only slot 0 enabled.
5. Invalid code:
   - Stimulus: frame 0x00A3.
   - Required: slot 1 dec_en=0 and bcd_err rises during slot 1 SHOW and stays 1 after a valid frame is loaded; only rst clears it.
6. Reset mid-frame:
   - Stimulus: assert rst during slot 2 with pending full.
   - Required: next cycle digit_sel=0, load_ready=1, bcd_err=0. After release, scan restarts at slot 0 displaying 0x0000.
